wb_burst_ram_slave: RTL and testbench
=====================================

// Module: wb_burst_ram_slave
// PURPOSE
//  Parametrised Wishbone B4 slave: word-addressed RAM with per-byte write enables.
//  Supports registered-feedback incrementing bursts (cti_i), programmable wait states and an error response.
//  Acts as the on-chip memory/target endpoint behind the bus fabric and as the reference target for bus agents.
// PARAMETERS
//  DATA_W       32    data bus width in bits; multiple of 8, >= 8
//  ADDR_W       26    byte-address width of addr_i
//  DEPTH        1024  number of DATA_W-bit words in the RAM
//  WAIT_STATES  0     extra cycles inserted before the first ack of each cycle/burst (0..15)
//  BURST_EN     1     1: honour cti_i=3'b010 bursts; 0: every access treated as classic
// PORTS
//  clk     in   1         bus clock; all state updates on rising edge
//  reset   in   1         asynchronous, active-low reset
//  cyc_i   in   1         bus cycle in progress
//  stb_i   in   1         strobe / valid transfer request
//  we_i    in   1         1 = write, 0 = read
//  addr_i  in   ADDR_W    byte address; word index = addr_i[ADDR_W-1:$clog2(DATA_W/8)]
//  dat_i   in   DATA_W    write data
//  sel_i   in   DATA_W/8  byte enables; sel_i[k] covers dat_i[8k+7:8k]
//  cti_i   in   3         cycle type: 000 classic, 010 incr burst, 111 end-of-burst; others = classic
//  dat_o   out  DATA_W    read data, valid only while ack_o=1 and we_i=0
//  ack_o   out  1         normal termination, one per beat
//  err_o   out  1         error termination (out-of-range word index), one per beat
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; ack_o=0, err_o=0, dat_o=0; wait counter=0; RAM contents not cleared.
//  Term outputs: ack_o = ack_r & cyc_i & stb_i; err_o = err_r & cyc_i & stb_i; never both 1.
//  FSM states: IDLE, WAIT, BEAT, BURST.
//  IDLE: on cyc_i&stb_i, latch word index into addr_cnt.
//    WAIT_STATES=0 -> BEAT. Otherwise -> WAIT with cnt=WAIT_STATES.
//  WAIT: cnt decrements each cycle; at cnt=1 -> BEAT. If cyc_i|stb_i drops -> IDLE.
//  BEAT: exactly one term beat (ack_r or err_r = 1). Latency from the first request cycle is 1+WAIT_STATES.
//    If BURST_EN and cti_i=010 in this cycle -> BURST with addr_cnt+1. Else -> IDLE.
//  BURST: a term beat every cycle while cyc_i&stb_i; addr_cnt increments after each beat.
//    Master's addr_i is ignored after the first beat.
//    Beat with cti_i=111 is the last beat -> IDLE, term regs cleared next cycle.
//    cyc_i or stb_i low -> IDLE immediately; no further beats, no write.
//  Range: word index >= DEPTH gives err_r instead of ack_r. No RAM write; dat_o=0.
//    Burst increment past DEPTH-1 does not wrap: that beat and every later beat err.
//  Write: on the rising edge ending a cycle with ack_o=1 and we_i=1.
//    mem[addr_cnt] byte k <= dat_i byte k wherever sel_i[k]=1; other bytes unchanged. sel_i=0 -> ack, no change.
//  Read: dat_o registered from mem[next addr_cnt] so it is valid in the ack cycle.
//    Read-after-write to the same word in the next beat returns the new data (write-first bypass).
//    dat_o is 0 when ack_o=0.
//  we_i is sampled per beat; changing it mid-burst is legal.
//  Reset asserted mid-burst: ack/err drop asynchronously; the in-flight write is not performed.
// TESTING
//  1 Classic write 0xDEADBEEF, sel=1111 @0x10, then read @0x10, WS=0 -> ack 1 cycle after stb; dat_o=0xDEADBEEF.
//  2 Byte-lane write sel=0100, dat=0x00AA0000 onto 0x11223344 -> readback 0x11AA3344; sel=0000 write -> value unchanged, ack seen.
//  3 Incr burst of 4 writes from word 8 (cti 010,010,010,111), then 4-beat read burst -> 4 consecutive acks each.
//    Data matches; ack low the cycle after the 111 beat.
//  4 WAIT_STATES=3 classic read -> ack exactly 4 cycles after the first stb; stb dropped during WAIT -> no ack, FSM back to IDLE.
//  5 Read @word DEPTH -> err_o=1, ack_o=0.
//    Burst starting at DEPTH-2 -> ack, ack, err, err; memory at DEPTH-2..1 only.
//  6 Assert reset during beat 2 of a write burst -> ack_o=0 immediately; word of beat 2 unchanged; next classic access acks normally.

Source files
------------

// File: rtl/wb_burst_ram_slave_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_if : Wishbone B4 bus bundle with master and slave views.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 26
);
    logic                  cyc_i;
    logic                  stb_i;
    logic                  we_i;
    logic [ADDR_W-1:0]     addr_i;
    logic [DATA_W-1:0]     dat_i;
    logic [DATA_W/8-1:0]   sel_i;
    logic [2:0]            cti_i;
    logic [DATA_W-1:0]     dat_o;
    logic                  ack_o;
    logic                  err_o;

    modport slave (
        input  cyc_i, stb_i, we_i, addr_i, dat_i, sel_i, cti_i,
        output dat_o, ack_o, err_o
    );

    modport master (
        output cyc_i, stb_i, we_i, addr_i, dat_i, sel_i, cti_i,
        input  dat_o, ack_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_burst_ram_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_burst_ram_slave : Wishbone B4 word RAM with byte enables, incrementing  |
// | bursts, programmable wait states and out-of-range error termination.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wb_burst_ram_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 26,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0,
    parameter int BURST_EN    = 1
) (
    input  wire  clk,
    input  wire  reset,
    wb_if.slave  bus
);
    localparam int              c_bytes = DATA_W / 8;
    localparam int              c_boff  = $clog2(c_bytes);
    localparam int              c_widx  = ADDR_W - c_boff;
    localparam int              c_mw    = $clog2(DEPTH);
    localparam logic [c_widx:0] c_depth = (c_widx + 1)'(DEPTH);
    localparam logic [c_widx:0] c_one   = (c_widx + 1)'(1);
    localparam logic [3:0]      c_ws    = 4'(WAIT_STATES);
    localparam bit              c_burst = (BURST_EN != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BEAT  = 2'd2,
        ST_BURST = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_widx:0]     r_addr;
    logic [c_widx:0]     w_addr_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic                r_ack;
    logic                r_err;
    logic                w_beat_nxt;
    logic                w_range_nxt;
    logic [DATA_W-1:0]   r_dat;
    logic [DATA_W-1:0]   w_rd_nxt;
    logic [DATA_W-1:0]   w_merged;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                w_req;
    logic                w_incr;
    logic                w_ack;
    logic                w_wr;
    logic                w_unused;

    function automatic logic f_in_range(input logic [c_widx:0] a);
        return a < c_depth;
    endfunction

    assign w_req    = bus.cyc_i & bus.stb_i;
    assign w_incr   = c_burst && (bus.cti_i == 3'b010);
    assign w_ack    = r_ack & w_req;
    assign w_wr     = w_ack & bus.we_i;
    assign w_unused = &{1'b0, bus.addr_i};

    assign bus.ack_o = w_ack;
    assign bus.err_o = r_err & w_req;
    assign bus.dat_o = w_ack ? r_dat : '0;

    // Counter carries one extra bit and stops once out of range, so a burst
    // running off the end keeps erroring instead of wrapping back into the RAM.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_beat_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_addr_nxt = {1'b0, bus.addr_i[ADDR_W-1:c_boff]};
                    if (c_ws == 4'd0) begin
                        w_state_nxt = ST_BEAT;
                        w_beat_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = c_ws;
                    end
                end
            end
            ST_WAIT: begin
                if (!w_req) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt <= 4'd1) begin
                    w_state_nxt = ST_BEAT;
                    w_beat_nxt  = 1'b1;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_BEAT, ST_BURST: begin
                if (w_req && w_incr) begin
                    w_state_nxt = ST_BURST;
                    w_beat_nxt  = 1'b1;
                    if (f_in_range(r_addr)) begin
                        w_addr_nxt = r_addr + c_one;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_range_nxt = f_in_range(w_addr_nxt);

    always_comb begin
        w_merged = r_mem[r_addr[c_mw-1:0]];
        for (int k = 0; k < c_bytes; k++) begin
            if (bus.sel_i[k]) begin
                w_merged[8*k +: 8] = bus.dat_i[8*k +: 8];
            end
        end
    end

    // Next beat's read data is fetched a cycle early; a write landing on the
    // same word this cycle is forwarded so the read sees the new value.
    always_comb begin
        w_rd_nxt = '0;
        if (w_beat_nxt && w_range_nxt) begin
            if (w_wr && (w_addr_nxt == r_addr)) begin
                w_rd_nxt = w_merged;
            end else begin
                w_rd_nxt = r_mem[w_addr_nxt[c_mw-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_beat_nxt & w_range_nxt;
            r_err   <= w_beat_nxt & ~w_range_nxt;
            r_dat   <= w_rd_nxt;
        end
    end

    // RAM contents survive reset; r_ack is cleared asynchronously, which
    // suppresses any write that was in flight when reset hit.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_addr[c_mw-1:0]] <= w_merged;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_wb_burst_ram_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wb_burst_ram_slave : randomized scoreboard bench for two RAM slaves    |
// | (zero and three wait states) sharing one bus master.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_wb_burst_ram_slave;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 64;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wb_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
    wb_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

    wb_burst_ram_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(0), .BURST_EN(1))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    wb_burst_ram_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(3), .BURST_EN(1))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));

    logic          m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_dat = '0;
    logic [3:0]    m_sel = '0;
    logic [2:0]    m_cti = '0;
    int            tgt = 0;

    assign bus0.cyc_i = m_cyc & (tgt == 0);
    assign bus0.stb_i = m_stb & (tgt == 0);
    assign bus1.cyc_i = m_cyc & (tgt == 1);
    assign bus1.stb_i = m_stb & (tgt == 1);
    assign bus0.we_i = m_we;    assign bus1.we_i = m_we;
    assign bus0.addr_i = m_addr; assign bus1.addr_i = m_addr;
    assign bus0.dat_i = m_dat;  assign bus1.dat_i = m_dat;
    assign bus0.sel_i = m_sel;  assign bus1.sel_i = m_sel;
    assign bus0.cti_i = m_cti;  assign bus1.cti_i = m_cti;

    logic          s_ack, s_err;
    logic [DW-1:0] s_dat;
    assign s_ack = (tgt == 0) ? bus0.ack_o : bus1.ack_o;
    assign s_err = (tgt == 0) ? bus0.err_o : bus1.err_o;
    assign s_dat = (tgt == 0) ? bus0.dat_o : bus1.dat_o;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference memory: one array per target, updated beat by beat from the bus rules.
    logic [31:0] model [2][DEPTH];

    int          q_cyc[$];
    bit          q_err[$];
    bit          q_chk[$];
    logic [31:0] q_dat[$];
    string       q_tag[$];

    bit          b_we  [64];
    logic [31:0] b_dat [64];
    logic [3:0]  b_sel [64];

    function automatic logic [31:0] f_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every termination pops one expectation (cycle, kind, data).
    always @(negedge clk) begin
        if (s_ack || s_err) begin
            n_tests++;
            if (q_cyc.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_term: cycle %0d ack=%b err=%b, required no termination", cyc_n, s_ack, s_err);
            end else begin
                int          ec;
                bit          ee, ck;
                logic [31:0] ed;
                string       tg;
                ec = q_cyc.pop_front(); ee = q_err.pop_front(); ck = q_chk.pop_front();
                ed = q_dat.pop_front(); tg = q_tag.pop_front();
                if (cyc_n != ec || s_err !== ee || s_ack !== !ee || (ck && s_dat !== ed) || (ee && s_dat !== 32'h0)) begin
                    n_fail++;
                    $display("FAIL %s: got cycle %0d ack=%b err=%b dat=0x%08h, required cycle %0d err=%b dat=0x%08h (checked=%b)",
                             tg, cyc_n, s_ack, s_err, s_dat, ec, ee, ed, ck || ee);
                end
            end
        end
    end

    task automatic drive_idle();
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_sel = '0; m_cti = '0; m_addr = '0; m_dat = '0;
    endtask

    task automatic set_beat(input int i, input int start, input bit burst, input int n);
        m_cyc = 1'b1; m_stb = 1'b1;
        m_we  = b_we[i]; m_sel = b_sel[i]; m_dat = b_dat[i];
        m_addr = (i == 0) ? AW'(start * 4 + int'($urandom_range(0, 3))) : AW'($urandom);
        m_cti = !burst ? 3'b000 : ((i == n - 1) ? 3'b111 : 3'b010);
    endtask

    task automatic run_txn(input int t, input int start, input int n, input bit burst, input string tag);
        int ws, c0, word, waited;
        bit got;
        ws = (t == 1) ? 3 : 0;
        @(posedge clk); #1;
        tgt = t;
        c0  = cyc_n;
        for (int i = 0; i < n; i++) begin
            word = start + i;
            q_cyc.push_back(c0 + 1 + ws + i);
            q_err.push_back(word >= DEPTH);
            q_chk.push_back(!b_we[i] && word < DEPTH);
            q_dat.push_back((word < DEPTH) ? model[t][word] : 32'h0);
            q_tag.push_back(tag);
            if (b_we[i] && word < DEPTH) model[t][word] = f_merge(model[t][word], b_dat[i], b_sel[i]);
        end
        set_beat(0, start, burst, n);
        got = 1'b0; waited = 0;
        while (!got && waited < 20) begin
            @(negedge clk);
            if (s_ack || s_err) got = 1'b1;
            else begin @(posedge clk); #1; waited++; end
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: got no termination in 20 cycles, required one", tag);
            q_cyc.delete(); q_err.delete(); q_chk.delete(); q_dat.delete(); q_tag.delete();
            drive_idle();
            return;
        end
        for (int i = 1; i < n; i++) begin
            @(posedge clk); #1;
            set_beat(i, start, burst, n);
        end
        // Request held one cycle past the last beat, then abandoned: no termination may appear.
        @(posedge clk); #1;
        m_cti = 3'b000; m_we = 1'b0; m_sel = '0; m_addr = AW'($urandom);
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic fill(input int n, input bit we, input logic [3:0] sel);
        for (int i = 0; i < n; i++) begin
            b_we[i] = we; b_sel[i] = sel; b_dat[i] = $urandom;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old21;
        drive_idle();
        @(negedge clk);
        check("reset_ack0", {29'd0, bus0.ack_o, bus0.err_o, 1'b0}, 32'h0);
        check("reset_dat0", bus0.dat_o, 32'h0);
        check("reset_ack1", {29'd0, bus1.ack_o, bus1.err_o, 1'b0}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        fill(64, 1'b1, 4'hF); run_txn(0, 0, 64, 1'b1, "preload0");
        fill(64, 1'b1, 4'hF); run_txn(1, 0, 64, 1'b1, "preload1");

        b_we[0] = 1'b1; b_dat[0] = 32'hDEADBEEF; b_sel[0] = 4'hF;
        run_txn(0, 4, 1, 1'b0, "classic_write");
        b_we[0] = 1'b0;
        run_txn(0, 4, 1, 1'b0, "classic_read");

        b_we[0] = 1'b1; b_dat[0] = 32'h11223344; b_sel[0] = 4'hF;
        run_txn(0, 5, 1, 1'b0, "lane_base");
        b_dat[0] = 32'h00AA0000; b_sel[0] = 4'b0100;
        run_txn(0, 5, 1, 1'b0, "lane_write");
        b_we[0] = 1'b0;
        run_txn(0, 5, 1, 1'b0, "lane_read");
        b_we[0] = 1'b1; b_dat[0] = 32'hFFFFFFFF; b_sel[0] = 4'b0000;
        run_txn(0, 5, 1, 1'b0, "sel0_write");
        b_we[0] = 1'b0;
        run_txn(0, 5, 1, 1'b0, "sel0_read");

        fill(4, 1'b1, 4'hF); run_txn(0, 8, 4, 1'b1, "burst_write");
        fill(4, 1'b0, 4'hF); run_txn(0, 8, 4, 1'b1, "burst_read");

        fill(1, 1'b0, 4'hF); run_txn(1, 3, 1, 1'b0, "ws3_read");
        @(posedge clk); #1;
        tgt = 1; m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_cti = 3'b000; m_addr = AW'(12 * 4);
        repeat (2) begin @(posedge clk); #1; end
        drive_idle();
        run_txn(1, 7, 1, 1'b0, "ws3_after_abort");
        fill(3, 1'b0, 4'hF); run_txn(1, 10, 3, 1'b1, "ws3_burst_read");

        fill(1, 1'b0, 4'hF); run_txn(0, DEPTH, 1, 1'b0, "range_read");
        fill(4, 1'b1, 4'hF); run_txn(0, DEPTH - 2, 4, 1'b1, "range_burst_write");
        fill(4, 1'b0, 4'hF); run_txn(0, DEPTH - 2, 4, 1'b1, "range_burst_read");

        // Reset lands during the second beat of a write burst.
        old21 = model[0][21];
        @(posedge clk); #1;
        tgt = 0;
        q_cyc.push_back(cyc_n + 1); q_err.push_back(1'b0); q_chk.push_back(1'b0);
        q_dat.push_back(32'h0); q_tag.push_back("rst_beat1");
        model[0][20] = 32'hA5A5_0014;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_sel = 4'hF; m_dat = 32'hA5A5_0014;
        m_addr = AW'(20 * 4); m_cti = 3'b010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_dat = 32'h5A5A_0015; m_addr = AW'($urandom);
        #1;
        check("rst_beat2_ack_before", {31'd0, bus0.ack_o}, 32'h1);
        #1;
        reset = 1'b0;
        #1;
        check("rst_beat2_ack_dropped", {31'd0, bus0.ack_o}, 32'h0);
        @(posedge clk); #1;
        drive_idle();
        reset = 1'b1;
        if (q_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL rst_beat1_missing: got %0d pending terms, required 0", q_cyc.size());
            q_cyc.delete(); q_err.delete(); q_chk.delete(); q_dat.delete(); q_tag.delete();
        end
        n_tests++;
        fill(1, 1'b0, 4'hF); run_txn(0, 21, 1, 1'b0, "rst_word21_unchanged");
        check("rst_model21", model[0][21], old21);
        run_txn(0, 20, 1, 1'b0, "rst_word20_written");

        for (int k = 0; k < 120; k++) begin
            int  t, n, start;
            bit  burst;
            t     = int'($urandom_range(0, 1));
            burst = ($urandom_range(0, 2) != 0);
            n     = burst ? int'($urandom_range(2, 6)) : 1;
            start = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH - 3, DEPTH + 4))
                                                : int'($urandom_range(0, DEPTH - 1));
            for (int i = 0; i < n; i++) begin
                b_we[i] = $urandom_range(0, 1) != 0; b_sel[i] = 4'($urandom); b_dat[i] = $urandom;
            end
            run_txn(t, start, n, burst, "random");
        end

        repeat (4) @(posedge clk);
        n_tests++;
        if (q_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expect: got %0d pending terminations, required 0", q_cyc.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
